// File: rtl/spi_pkg.sv
// Shared SPI definitions: receive FSM states, default byte width and the
// command/register constants used by the SPI controller.
package spi_pkg;
  localparam int SPI_DATA_W = 8;

  localparam logic [7:0] CMD_WRITE     = 8'h0A;
  localparam logic [7:0] CMD_READ      = 8'h0B;
  localparam logic [7:0] REG_XDATA     = 8'h08;
  localparam logic [7:0] REG_POWER_CTL = 8'h2D;

  typedef enum logic {IDLE, ACTIVE} rx_state_t;
endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   push, wdata  write request; accepted when not full or when popping
//   pop          read request; ignored when empty
//   rdata        head entry (valid while !empty)
//   full, empty  status
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module sync_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][DATA_W-1:0] mem;
  logic [AW:0]                  wr_ptr, rd_ptr;
  logic                         wr_en, rd_en;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_en = pop & ~empty;
  // A full FIFO can still take a write when the head leaves in the same cycle.
  assign wr_en = push & (~full | rd_en);
  assign rdata = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr[AW-1:0]] <= wdata;
        wr_ptr              <= wr_ptr + (AW+1)'(1);
      end
      if (rd_en) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end
endmodule

// File: rtl/spi_rx_deser.sv
// SPI receive deserializer. Samples MISO on rising SCLK edges (SCLK treated
// as data in the clk domain) while the receive window is open, assembles
// MSB-first bytes and queues them in a FWFT FIFO with a valid/ready output.
// Ports:
//   clk, rst_n          system clock, async active-low reset
//   sclk, cs, receive   serial clock, chip select (low active), receive enable
//   miso                asynchronous serial data input
//   rx_data/rx_valid/rx_ready  output byte stream
//   frame_done/frame_err       one-cycle pulses on window close
//   overflow/ovf_clr           sticky drop flag and its clear
//   byte_count          accepted byte count, saturating (SPI_RX_STATS_EN only)
module spi_rx_deser
  import spi_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = SPI_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclk,
  input  logic              cs,
  input  logic              receive,
  input  logic              miso,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              frame_done,
  output logic              frame_err,
  output logic              overflow,
`ifdef SPI_RX_STATS_EN
  output logic [15:0]       byte_count,
`endif
  input  logic              ovf_clr
);
  localparam int CW = $clog2(DATA_W);
  localparam logic [CW-1:0] LAST = CW'(DATA_W-1);

  rx_state_t         state, state_nx;
  logic [CW-1:0]     bit_cnt, cnt_nx;
  logic [DATA_W-1:0] shift, shift_nx, push_data;
  logic              miso_q, miso_s, sclk_d;
  logic              edge_s, window, push, pop, full, empty;
  logic              fd_nx, fe_nx, push_ok;

  assign edge_s    = sclk & ~sclk_d;
  assign window    = receive & ~cs;
  assign push_data = {shift[DATA_W-2:0], miso_s};
  assign rx_valid  = ~empty;
  assign pop       = rx_valid & rx_ready;
  assign push_ok   = push & (~full | pop);

  always_comb begin
    state_nx = state;
    cnt_nx   = bit_cnt;
    shift_nx = shift;
    push     = 1'b0;
    fd_nx    = 1'b0;
    fe_nx    = 1'b0;
    case (state)
      IDLE: begin
        cnt_nx = '0;
        if (window) state_nx = ACTIVE;
      end
      ACTIVE: begin
        // Edge handling first so a byte completing on the closing cycle
        // is still pushed and does not count as partial.
        if (edge_s) begin
          shift_nx = push_data;
          if (bit_cnt == LAST) begin
            push   = 1'b1;
            cnt_nx = '0;
          end else begin
            cnt_nx = bit_cnt + CW'(1);
          end
        end
        if (!window) begin
          state_nx = IDLE;
          fd_nx    = 1'b1;
          fe_nx    = (cnt_nx != '0);
          cnt_nx   = '0;
          shift_nx = '0;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shift      <= '0;
      miso_q     <= 1'b0;
      miso_s     <= 1'b0;
      sclk_d     <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      state      <= state_nx;
      bit_cnt    <= cnt_nx;
      shift      <= shift_nx;
      miso_q     <= miso;
      miso_s     <= miso_q;
      sclk_d     <= sclk;
      frame_done <= fd_nx;
      frame_err  <= fe_nx;
      // Set dominates clear.
      overflow   <= (push & ~push_ok) | (overflow & ~ovf_clr);
    end
  end

`ifdef SPI_RX_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             byte_count <= '0;
    else if (push_ok && byte_count != '1)   byte_count <= byte_count + 16'd1;
  end
`endif

  sync_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (push_data),
    .pop   (pop),
    .rdata (rx_data),
    .full  (full),
    .empty (empty)
  );
endmodule
